// File: rtl/seg_pkg.sv
// seg_pkg: shared scan-controller types, blank code and index-width helper.
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam logic [3:0] SEG_BLANK_CODE = 4'hF;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: display-word load handshake (valid/ready) between producer and scan controller.
interface seg_scan_if #(parameter int NUM_DIGITS = 4) ();
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    in_valid;
  logic                    in_ready;
  modport master (output bcd_in, dp_in, in_valid, input in_ready);
  modport slave  (input bcd_in, dp_in, in_valid, output in_ready);
endinterface

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: per-slot cycle counter emitting end-of-blank and end-of-slot strobes.
module seg_scan_tick #(
  parameter int TICK_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_show_start,
  output logic o_slot_end
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] r_cnt;
  assign o_show_start = r_cnt == CW'(BLANK_CYC - 1);
  assign o_slot_end   = r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (!i_run || o_slot_end) ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan with blanking gaps and frame-aligned word updates.
// Define SEG_SCAN_LZB_EN to blank leading zeros on digits above digit 0.
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_if.slave             bus,
  output logic [3:0]            sin,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);
  localparam int IDX_W = idx_w(NUM_DIGITS);
  state_t                       r_state, w_next;
  logic [IDX_W-1:0]             r_idx, w_idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]   r_shadow, r_pend;
  logic [NUM_DIGITS-1:0]        r_shadow_dp, r_pend_dp;
  logic                         r_in_ready;
  logic                         w_show_start, w_slot_end, w_last, w_show, w_copy;
  logic [3:0]                   w_nib;

  seg_scan_tick #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (enable && r_state != IDLE),
    .o_show_start (w_show_start),
    .o_slot_end   (w_slot_end)
  );

  assign w_last       = r_idx == IDX_W'(NUM_DIGITS - 1);
  assign w_show       = enable && r_state == SHOW;
  assign bus.in_ready = r_in_ready;
  // Pending word lands on the shadow at the frame_done output cycle, or immediately while stopped.
  assign w_copy       = !r_in_ready && (!enable || frame_done);

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] w_lz;
  always_comb begin
    logic z;
    z = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && r_shadow[i] == 4'd0;
      w_lz[i] = z;
    end
  end
  assign w_nib = w_lz[r_idx] ? SEG_BLANK_CODE : r_shadow[r_idx];
`else
  assign w_nib = r_shadow[r_idx];
`endif

  always_comb begin
    w_next    = !enable ? IDLE :
                r_state == IDLE ? BLANK :
                (r_state == BLANK && w_show_start) ? SHOW :
                (r_state == SHOW && w_slot_end) ? BLANK : r_state;
    w_idx_nxt = !enable ? '0 :
                (r_state == SHOW && w_slot_end) ? (w_last ? '0 : r_idx + IDX_W'(1)) : r_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      sin         <= SEG_BLANK_CODE;
      dp_out      <= 1'b0;
      dig_en      <= '0;
      frame_done  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_shadow    <= {NUM_DIGITS{SEG_BLANK_CODE}};
      r_shadow_dp <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
    end else begin
      r_state    <= w_next;
      r_idx      <= w_idx_nxt;
      sin        <= w_show ? w_nib : SEG_BLANK_CODE;
      dp_out     <= w_show && r_shadow_dp[r_idx];
      dig_en     <= w_show ? NUM_DIGITS'(1) << r_idx : '0;
      frame_done <= w_show && w_slot_end && w_last;
      if (bus.in_valid && r_in_ready) begin
        r_pend     <= bus.bcd_in;
        r_pend_dp  <= bus.dp_in;
        r_in_ready <= 1'b0;
      end else if (w_copy) begin
        r_shadow    <= r_pend;
        r_shadow_dp <= r_pend_dp;
        r_in_ready  <= 1'b1;
      end
    end
  end
endmodule
